// File: rtl/snake_engine.sv
// snake_engine -- single-clock Snake game core for a 640x480 raster.
//
// The playfield is 32x24 cells of CELL_PX pixels. A 16-bit LFSR runs every
// cycle and supplies food positions. The snake moves one cell every
// MOVE_FRAMES frames. Frames are marked by the raster position hpos=0, vpos=480.
//
// Optional build macro:
//   SNAKE_WRAP_EN  when defined, the head wraps across the grid edges.
//                  When undefined (default), leaving the grid ends the game.
//
// Ports:
//   clk_i         pixel clock; the only clock
//   reset_ni      synchronous, active-low reset
//   hpos, vpos    raster column/row from the timing generator
//   display_on_i  high inside the visible 640x480 area
//   btn_i         one-hot direction request {up,down,left,right}
//   start_i       level; starts a game from IDLE or DEAD
//   rgb_o         registered pixel colour {R4,G4,B4}, one cycle after hpos/vpos
//   score_o       food eaten in the current game, saturating at 255
//   game_over_o   high while in DEAD
//   state_o       debug view of the FSM state (0 IDLE, 1 RUN, 2 DEAD)
//
// Direction handshake: there is no valid/ready pair. A btn_i value is accepted
// in the cycle it is sampled if it is one-hot and does not reverse the snake.
// Accepted requests are held as the pending direction. The pending direction
// takes effect at the next move.
module snake_engine #(
  parameter int MAX_LEN     = 16,
  parameter int MOVE_FRAMES = 8,
  parameter int CELL_PX     = 20
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on_i,
  input  logic [3:0]  btn_i,
  input  logic        start_i,
  output logic [11:0] rgb_o,
  output logic [7:0]  score_o,
  output logic        game_over_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam int             LW        = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]  LEN_MAX   = LW'(MAX_LEN);
  localparam logic [5:0]     MOVE_LAST = 6'(MOVE_FRAMES - 1);
  localparam logic [9:0]     CELL_W    = 10'(CELL_PX);
  localparam logic [3:0]     D_UP      = 4'b1000;
  localparam logic [3:0]     D_DOWN    = 4'b0100;
  localparam logic [3:0]     D_LEFT    = 4'b0010;
  localparam logic [3:0]     D_RIGHT   = 4'b0001;

  state_t        r_state;
  logic [4:0]    r_seg_x [MAX_LEN];
  logic [4:0]    r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [3:0]    r_dir;
  logic [3:0]    r_pend;
  logic [5:0]    r_frame_cnt;
  logic [15:0]   r_lfsr;
  logic [4:0]    r_food_x;
  logic [4:0]    r_food_y;
  logic [7:0]    r_score;
  logic [11:0]   r_rgb;

  logic          w_frame_tick;
  logic          w_move_tick;
  logic          w_enter_run;
  logic [3:0]    w_cur_dir;
  logic          w_btn_ok;
  logic [4:0]    w_nx;
  logic [4:0]    w_ny;
  logic          w_edge;
  logic          w_wall_hit;
  logic          w_self_hit;
  logic          w_hit;
  logic          w_eat;
  logic          w_food_on_snake;
  logic          w_lfsr_fb;
  logic [4:0]    w_lfsr_x;
  logic [4:0]    w_lfsr_y;
  logic [9:0]    w_col;
  logic [9:0]    w_row;
  logic          w_hit_head;
  logic          w_hit_body;
  logic          w_hit_food;
  logic [11:0]   w_pix_next;

  assign w_frame_tick = (hpos == 10'd0) && (vpos == 10'd480);
  assign w_move_tick  = (r_state == S_RUN) && w_frame_tick && (r_frame_cnt == MOVE_LAST);
  assign w_enter_run  = (r_state != S_RUN) && start_i;

  // On a move cycle the pending direction becomes current, so the
  // reverse check must use it. Otherwise two quick presses could fold the
  // snake back onto itself.
  assign w_cur_dir = w_move_tick ? r_pend : r_dir;
  assign w_btn_ok  = (btn_i != 4'd0) && ((btn_i & (btn_i - 4'd1)) == 4'd0) &&
                     (btn_i != {w_cur_dir[2], w_cur_dir[3], w_cur_dir[0], w_cur_dir[1]});

  // Next head position. w_edge flags a step that leaves the grid.
  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_edge = 1'b0;
    case (r_pend)
      D_UP: begin
        if (r_seg_y[0] == 5'd0) begin w_edge = 1'b1; w_ny = 5'd23; end
        else w_ny = r_seg_y[0] - 5'd1;
      end
      D_DOWN: begin
        if (r_seg_y[0] == 5'd23) begin w_edge = 1'b1; w_ny = 5'd0; end
        else w_ny = r_seg_y[0] + 5'd1;
      end
      D_LEFT: begin
        if (r_seg_x[0] == 5'd0) begin w_edge = 1'b1; w_nx = 5'd31; end
        else w_nx = r_seg_x[0] - 5'd1;
      end
      default: begin
        if (r_seg_x[0] == 5'd31) begin w_edge = 1'b1; w_nx = 5'd0; end
        else w_nx = r_seg_x[0] + 5'd1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign w_wall_hit = 1'b0;
`else
  assign w_wall_hit = w_edge;
`endif

  // The tail cell (index length-1) is vacated by this move, so it is excluded.
  always_comb begin
    w_self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if ((i < int'(r_len) - 1) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny))
        w_self_hit = 1'b1;
    end
  end

  assign w_hit = w_wall_hit || w_self_hit;
  assign w_eat = (w_nx == r_food_x) && (w_ny == r_food_y);

  always_comb begin
    w_food_on_snake = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(r_len)) && (r_seg_x[i] == r_food_x) && (r_seg_y[i] == r_food_y))
        w_food_on_snake = 1'b1;
    end
  end

  // Taps 16,14,13,11 give a maximal-length sequence.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_x  = r_lfsr[4:0];
  assign w_lfsr_y  = (r_lfsr[9:5] >= 5'd24) ? (r_lfsr[9:5] - 5'd24) : r_lfsr[9:5];

  // Pixel to cell mapping and colour priority.
  assign w_col      = hpos / CELL_W;
  assign w_row      = vpos / CELL_W;
  assign w_hit_head = (w_col == {5'd0, r_seg_x[0]}) && (w_row == {5'd0, r_seg_y[0]});
  assign w_hit_food = (w_col == {5'd0, r_food_x}) && (w_row == {5'd0, r_food_y});

  always_comb begin
    w_hit_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(r_len)) && (w_col == {5'd0, r_seg_x[i]}) && (w_row == {5'd0, r_seg_y[i]}))
        w_hit_body = 1'b1;
    end
  end

  always_comb begin
    if (!display_on_i)         w_pix_next = 12'h000;
    else if (w_hit_head)       w_pix_next = 12'h0F0;
    else if (w_hit_body)       w_pix_next = 12'h080;
    else if (w_hit_food)       w_pix_next = 12'hF00;
    else if (r_state == S_DEAD) w_pix_next = 12'h200;
    else                       w_pix_next = 12'h002;
  end

  always_ff @(posedge clk_i) begin
    // FSM, LFSR, food and pixel register.
    if (!reset_ni) begin
      r_state  <= S_IDLE;
      r_lfsr   <= 16'hACE1;
      r_food_x <= 5'd8;
      r_food_y <= 5'd8;
      r_rgb    <= 12'h000;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_rgb  <= w_pix_next;
      case (r_state)
        S_IDLE, S_DEAD: if (start_i) r_state <= S_RUN;
        S_RUN:          if (w_move_tick && w_hit) r_state <= S_DEAD;
        default:        r_state <= S_IDLE;
      endcase
      if (w_move_tick && !w_hit && w_eat) begin
        r_food_x <= w_lfsr_x;
        r_food_y <= w_lfsr_y;
      end else if ((r_state == S_RUN) && w_frame_tick && !(w_move_tick && w_hit) &&
                   w_food_on_snake) begin
        // Food under the snake keeps being re-rolled, once per frame, until it is clear.
        r_food_x <= w_lfsr_x;
        r_food_y <= w_lfsr_y;
      end
    end

    // Snake body, direction, length, score and frame counter.
    if (!reset_ni || w_enter_run) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i == 0) ? 5'd16 : ((i == 1) ? 5'd15 : 5'd14);
        r_seg_y[i] <= 5'd12;
      end
      r_len       <= LW'(3);
      r_dir       <= D_RIGHT;
      r_pend      <= D_RIGHT;
      r_frame_cnt <= 6'd0;
      r_score     <= 8'd0;
    end else if (r_state == S_RUN) begin
      if (w_btn_ok) r_pend <= btn_i;
      if (w_frame_tick) r_frame_cnt <= w_move_tick ? 6'd0 : (r_frame_cnt + 6'd1);
      if (w_move_tick && !w_hit) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny;
        r_dir      <= r_pend;
        if (w_eat) begin
          if (r_len != LEN_MAX)  r_len   <= r_len + LW'(1);
          if (r_score != 8'hFF)  r_score <= r_score + 8'd1;
        end
      end
    end
  end

  assign rgb_o       = r_rgb;
  assign score_o     = r_score;
  assign game_over_o = (r_state == S_DEAD);
  assign state_o     = r_state;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine -- directed bench for snake_engine.
// Driver tasks steer the snake by issuing frame ticks and button presses. A
// probe task pushes the expected value of one output onto a queue and pulses
// probe_req. The monitor pops the queue and compares against the DUT one cycle
// later. A full-grid scan counts the cells of each colour after food is eaten.
module tb_snake_engine;
  localparam int MOVE_FRAMES = 8;
  localparam int CELL        = 20;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on_i;
  logic [3:0]  btn_i;
  logic        start_i;
  logic [11:0] rgb_o;
  logic [7:0]  score_o;
  logic        game_over_o;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(16), .MOVE_FRAMES(MOVE_FRAMES), .CELL_PX(CELL)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .hpos(hpos), .vpos(vpos),
    .display_on_i(display_on_i), .btn_i(btn_i), .start_i(start_i),
    .rgb_o(rgb_o), .score_o(score_o), .game_over_o(game_over_o), .state_o(state_o)
  );

  // Scoreboard
  logic [11:0] exp_q[$];
  int          kind_q[$];   // 0 rgb, 1 score, 2 game_over, 3 state
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        probe_req = 1'b0;
  logic        probe_d   = 1'b0;
  logic [11:0] mon_act;
  logic [11:0] mon_exp;
  int          mon_kind;
  string       mon_name;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 12'h%03h, expected 12'h%03h", name, act, exp);
    end
  endtask

  always @(posedge clk) probe_d <= probe_req;

  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL monitor: output presented with no expected entry queued");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_kind)
          0:       mon_act = rgb_o;
          1:       mon_act = {4'd0, score_o};
          2:       mon_act = {11'd0, game_over_o};
          default: mon_act = {10'd0, state_o};
        endcase
        check(mon_name, mon_act, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    hpos = 10'd100; vpos = 10'd500; display_on_i = 1'b0;
  endtask

  task automatic expect_out(input int kind, input logic [11:0] exp, input string name,
                            input int h, input int v, input logic disp);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on_i = disp;
    exp_q.push_back(exp); kind_q.push_back(kind); name_q.push_back(name);
    probe_req = 1'b1;
    @(negedge clk);
    probe_req = 1'b0;
    idle_inputs();
  endtask

  task automatic exp_cell(input int x, input int y, input logic [11:0] exp, input string name);
    expect_out(0, exp, name, x * CELL + 5, y * CELL + 5, 1'b1);
  endtask

  task automatic exp_score(input logic [7:0] v, input string name);
    expect_out(1, {4'd0, v}, name, 100, 500, 1'b0);
  endtask

  task automatic exp_go(input logic v, input string name);
    expect_out(2, {11'd0, v}, name, 100, 500, 1'b0);
  endtask

  task automatic exp_state(input logic [1:0] v, input string name);
    expect_out(3, {10'd0, v}, name, 100, 500, 1'b0);
  endtask

  task automatic frame_tick();
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd480; display_on_i = 1'b0;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_move();
    repeat (MOVE_FRAMES) frame_tick();
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk); btn_i = b;
    @(negedge clk); btn_i = 4'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic scan_grid(output int n_head, output int n_body, output int n_food);
    n_head = 0; n_body = 0; n_food = 0;
    for (int idx = 0; idx <= 768; idx++) begin
      @(negedge clk);
      if (idx > 0) begin
        if (rgb_o == 12'h0F0) n_head++;
        if (rgb_o == 12'h080) n_body++;
        if (rgb_o == 12'hF00) n_food++;
      end
      if (idx < 768) begin
        hpos = 10'((idx % 32) * CELL + 5); vpos = 10'((idx / 32) * CELL + 5); display_on_i = 1'b1;
      end else idle_inputs();
    end
  endtask

  int n_head, n_body, n_food;

  initial begin
    reset_ni = 1'b0; btn_i = 4'd0; start_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset state (reset held low while probing)
    expect_out(0, 12'h000, "reset rgb", 320, 240, 1'b1);
    exp_score(8'd0, "reset score");
    exp_go(1'b0, "reset game_over");
    exp_state(2'd0, "reset state idle");
    @(negedge clk); reset_ni = 1'b1;

    // IDLE picture: initial snake, food (8,8), blue background
    exp_cell(16, 12, 12'h0F0, "idle head");
    exp_cell(15, 12, 12'h080, "idle body1");
    exp_cell(14, 12, 12'h080, "idle body2");
    exp_cell(13, 12, 12'h002, "idle background");
    exp_cell(8, 8, 12'hF00, "idle food");

    // Frozen in IDLE
    do_move();
    exp_cell(16, 12, 12'h0F0, "idle frozen head");
    exp_state(2'd0, "still idle");

    // Start
    pulse_start();
    exp_state(2'd1, "run after start");
    expect_out(0, 12'h0F0, "pixel 320,240 head", 320, 240, 1'b1);
    expect_out(0, 12'h000, "pixel 320,240 blanked", 320, 240, 1'b0);

    // First move right
    do_move();
    exp_cell(17, 12, 12'h0F0, "move1 head");
    exp_cell(16, 12, 12'h080, "move1 body");
    exp_cell(14, 12, 12'h002, "move1 tail vacated");
    exp_score(8'd0, "move1 score");

    // Reverse request ignored
    press(4'b0010);
    do_move();
    exp_cell(18, 12, 12'h0F0, "left ignored head");

    // Turn up
    press(4'b1000);
    do_move();
    exp_cell(18, 11, 12'h0F0, "up head");
    exp_cell(18, 12, 12'h080, "up body");
    repeat (3) do_move();
    exp_cell(18, 8, 12'h0F0, "up x4 head");

    // Turn left and run into the food at (8,8)
    press(4'b0010);
    repeat (10) do_move();
    exp_cell(8, 8, 12'h0F0, "eat head");
    exp_cell(11, 8, 12'h080, "eat grown tail");
    exp_score(8'd1, "eat score");
    repeat (3) frame_tick();
    scan_grid(n_head, n_body, n_food);
    check("scan head cells", 12'(n_head), 12'd1);
    check("scan body cells", 12'(n_body), 12'd3);
    check("scan food cells", 12'(n_food), 12'd1);

    // Reset on the very cycle of a move tick
    repeat (MOVE_FRAMES - 4) frame_tick();
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd480; display_on_i = 1'b1; reset_ni = 1'b0;
    exp_q.push_back(12'h000); kind_q.push_back(0); name_q.push_back("reset at move rgb");
    probe_req = 1'b1;
    @(negedge clk);
    probe_req = 1'b0; reset_ni = 1'b1;
    idle_inputs();
    exp_state(2'd0, "reset at move state");
    exp_score(8'd0, "reset at move score");
    exp_go(1'b0, "reset at move game_over");
    exp_cell(16, 12, 12'h0F0, "reset at move head");
    exp_cell(8, 8, 12'hF00, "reset at move food");

    // Run right into the wall
    pulse_start();
    repeat (15) do_move();
    exp_cell(31, 12, 12'h0F0, "edge head");
    exp_state(2'd1, "edge still run");
    do_move();
`ifdef SNAKE_WRAP_EN
    exp_state(2'd1, "wrap stays run");
    exp_cell(0, 12, 12'h0F0, "wrap head");
    exp_go(1'b0, "wrap game_over");
`else
    exp_state(2'd2, "wall dead");
    exp_go(1'b1, "wall game_over");
    exp_cell(31, 12, 12'h0F0, "dead head kept");
    exp_cell(30, 12, 12'h080, "dead body kept");
    exp_cell(0, 0, 12'h200, "dead background");
    do_move();
    exp_cell(31, 12, 12'h0F0, "dead frozen head");

    // Restart from DEAD
    pulse_start();
    exp_state(2'd1, "restart run");
    exp_go(1'b0, "restart game_over");
    exp_score(8'd0, "restart score");
    exp_cell(16, 12, 12'h0F0, "restart head");
`endif

    // Drain the scoreboard
    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
